// File: rtl/ram_stream_pkg.sv
// Shared defaults and FSM state encoding for the RAM streaming controller.
package ram_stream_pkg;

    localparam int unsigned RAM_STREAM_ADDR_W = 10;
    localparam int unsigned RAM_STREAM_DATA_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRdDrain,
        StWr,
        StFin
    } stream_state_e;

endpackage

// File: rtl/ram_stream_fifo.sv
// Occupancy-counted synchronous skid FIFO; DEPTH must be a power of two.
module ram_stream_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       CLOCK,
    input  logic                       RESET_N,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    count_q;

    // Storage is cleared too so the head word reads as zero during and after reset.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/ram_stream_ctrl.sv
// Streams a word range between a synchronous RAM and valid/ready ports.
// Optional macro RAM_STREAM_BOUNDS_CHK_EN rejects commands running past the top of RAM.
module ram_stream_ctrl
    import ram_stream_pkg::*;
#(
    parameter int unsigned ADDR_W     = RAM_STREAM_ADDR_W,
    parameter int unsigned DATA_W     = RAM_STREAM_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] ram_addra,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_dataout
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CLAIM_W = CNT_W + 1;

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [ADDR_W-1:0] ram_addra_q, ram_addra_d;
    logic              ram_write_q, ram_write_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    // Read pipeline: address on the RAM port, then data on ram_dataout.
    logic              rd_issue_q, rd_pend_q;

    logic              cmd_ok;
    logic              rd_issue;
    logic              wr_accept;
    logic              pop;
    logic              last_pop;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CLAIM_W-1:0] claimed;

`ifdef RAM_STREAM_BOUNDS_CHK_EN
    localparam logic [ADDR_W+1:0] RamWords = (ADDR_W + 2)'(1) << ADDR_W;
    logic [ADDR_W+1:0] cmd_end;
    logic              err_q;

    assign cmd_end = {2'b00, base_addr} + {1'b0, length};
    assign cmd_ok  = (cmd_end <= RamWords);

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && start && !cmd_ok;
        end
    end

    assign err = err_q;
`else
    assign cmd_ok = 1'b1;
    assign err    = 1'b0;
`endif

    // Words already owed to the FIFO count against its space before a new read.
    assign claimed   = {1'b0, fifo_count} + {{(CLAIM_W - 1){1'b0}}, rd_issue_q}
                     + {{(CLAIM_W - 1){1'b0}}, rd_pend_q};
    assign rd_issue  = (state_q == StRd) && (remain_q != '0)
                     && (claimed < CLAIM_W'(FIFO_DEPTH));
    assign wr_accept = (state_q == StWr) && in_valid;
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && (fifo_count == CNT_W'(1)) && !rd_issue_q && !rd_pend_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The command direction lives in the state itself, so mode needs no register.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && cmd_ok) begin
                    if (length == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = mode ? StWr : StRd;
                    end
                end
            end
            StRd: begin
                if (rd_issue && (remain_q == (ADDR_W + 1)'(1))) state_d = StRdDrain;
            end
            StRdDrain: begin
                if (last_pop) state_d = StFin;
            end
            StWr: begin
                if (wr_accept && (remain_q == (ADDR_W + 1)'(1))) state_d = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StFin);
        in_ready = (state_q == StWr);
    end

    always_comb begin
        addr_d      = addr_q;
        remain_d    = remain_q;
        ram_addra_d = ram_addra_q;
        ram_write_d = 1'b0;
        ram_data_d  = ram_data_q;
        if ((state_q == StIdle) && start && cmd_ok) begin
            addr_d   = base_addr;
            remain_d = length;
        end
        if (rd_issue || wr_accept) begin
            ram_addra_d = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
            remain_d    = remain_q - (ADDR_W + 1)'(1);
        end
        if (wr_accept) begin
            ram_write_d = 1'b1;
            ram_data_d  = in_data;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            addr_q      <= '0;
            remain_q    <= '0;
            ram_addra_q <= '0;
            ram_write_q <= 1'b0;
            ram_data_q  <= '0;
            rd_issue_q  <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            ram_addra_q <= ram_addra_d;
            ram_write_q <= ram_write_d;
            ram_data_q  <= ram_data_d;
            rd_issue_q  <= rd_issue;
            rd_pend_q   <= rd_issue_q;
        end
    end

    assign ram_addra = ram_addra_q;
    assign ram_write = ram_write_q;
    assign ram_data  = ram_data_q;

    ram_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .push    (rd_pend_q),
        .wdata   (ram_dataout),
        .pop     (pop),
        .rdata   (out_data),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Randomized bench for ram_stream_ctrl against a word-level model of RAM contents.
module tb_ram_stream_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int WORDS = 1 << AW;

    logic          CLOCK = 1'b0;
    logic          RESET_N;
    logic          start, mode;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy, done, err;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] ram_addra;
    logic          ram_write;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_dataout;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] rd_exp [$];
    int            wr_addr_exp [$];
    logic [DW-1:0] wr_data_exp [$];

    ram_stream_ctrl #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .start       (start),
        .mode        (mode),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ram_addra   (ram_addra),
        .ram_write   (ram_write),
        .ram_data    (ram_data),
        .ram_dataout (ram_dataout)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [DW-1:0] init_word(input int i);
        if (i >= 16 && i < 20) return DW'(32'hA0 + i - 16);
        return DW'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous RAM: data for the sampled address appears one cycle later.
    logic [DW-1:0] ram [WORDS];
    bit            ram_init = 1'b0;
    always @(posedge CLOCK) begin
        if (!ram_init) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (ram_write) begin
            ram[ram_addra] <= ram_data;
        end
        ram_dataout <= ram[ram_addra];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // rpat: 0 = out_ready high, 1 = 1-0-0-1 pattern, 2 = random.
    task automatic run_cmd(input bit m, input int base, input int len, input int rpat,
                           input bit seqdata);
        bit            reject = 1'b0;
        bit            seen_done = 1'b0;
        bit            fin = 1'b0;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] wd;
        logic [AW-1:0] addr_before = '0;
        int            got_n = 0, acc_n = 0, done_n = 0, err_n = 0;
        int            first_c = -1, last_c = -1, it = 0, budget;
`ifdef RAM_STREAM_BOUNDS_CHK_EN
        reject = (base + len > WORDS);
`endif
        if (!m && !reject) begin
            for (int i = 0; i < len; i++) rd_exp.push_back(ref_mem[(base + i) % WORDS]);
        end
        budget = 8 * len + 40;
        while (!fin) begin
            @(negedge CLOCK);
            start     = (it == 0);
            mode      = m;
            base_addr = AW'(base);
            length    = (AW + 1)'(len);
            if (it == 0) addr_before = ram_addra;
            case (rpat)
                0:       out_ready = 1'b1;
                1:       out_ready = (it % 4 == 0) || (it % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (m && acc_n < len) begin
                in_valid = seqdata ? 1'b1 : ($urandom_range(0, 3) != 0);
                in_data  = seqdata ? DW'(acc_n + 1) : DW'($urandom());
            end else begin
                in_valid = 1'b0;
            end

            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) begin
                if (rd_exp.size() == 0) check("rd_extra", 1, 0);
                else check("rd_data", out_data, rd_exp.pop_front());
                got_n++;
                if (first_c < 0) first_c = it;
                last_c = it;
            end
            if (ram_write) begin
                if (wr_addr_exp.size() == 0) begin
                    check("wr_extra", 1, 0);
                end else begin
                    check("wr_addr", ram_addra, wr_addr_exp.pop_front());
                    check("wr_data", ram_data, wr_data_exp.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                wd = in_data;
                wr_addr_exp.push_back((base + acc_n) % WORDS);
                wr_data_exp.push_back(wd);
                ref_mem[(base + acc_n) % WORDS] = wd;
                acc_n++;
            end
            if (!m) check("in_ready_rd", in_ready, 0);
            if (it == 1) check("busy_start", busy, !reject);
            if (err) err_n++;
            if (seen_done) begin
                check("busy_after_done", busy, 0);
                fin = 1'b1;
            end
            if (done) begin
                done_n++;
                check("busy_at_done", busy, 1);
                seen_done = 1'b1;
            end
            if (reject && it == 4) fin = 1'b1;
            if (!fin && it >= budget) begin
                check("timeout", 0, 1);
                fin = 1'b1;
            end
            it++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("done_cnt", done_n, reject ? 0 : 1);
        check("err_cnt", err_n, reject ? 1 : 0);
        if (!m) begin
            check("rd_cnt", got_n, reject ? 0 : len);
            check("rd_left", rd_exp.size(), 0);
            if (rpat == 0 && got_n > 1) check("rd_burst", last_c - first_c, len - 1);
        end else begin
            check("wr_cnt", acc_n, reject ? 0 : len);
            check("wr_left", wr_addr_exp.size(), 0);
        end
        if (reject || len == 0) check("addr_hold", ram_addra, addr_before);
        rd_exp.delete();
        wr_addr_exp.delete();
        wr_data_exp.delete();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        RESET_N   = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        base_addr = '0;
        length    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (4) @(negedge CLOCK);
        check("rst_flags", {busy, done, err, in_ready, out_valid, ram_write}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_addr", ram_addra, 0);
        RESET_N = 1'b1;
        @(negedge CLOCK);
        check("post_rst_write", ram_write, 0);

        run_cmd(1'b0, 'h010, 4, 0, 1'b0);
        run_cmd(1'b1, 'h3FE, 4, 0, 1'b1);
        run_cmd(1'b0, 'h3FE, 4, 0, 1'b0);
        run_cmd(1'b0, 'h020, 8, 1, 1'b0);

        // Reset pulse in the middle of a 16-word read.
        @(negedge CLOCK);
        start = 1'b1; mode = 1'b0; base_addr = 'h100; length = 16; out_ready = 1'b1;
        @(negedge CLOCK);
        start = 1'b0;
        repeat (6) @(negedge CLOCK);
        check("mid_busy", busy, 1);
        RESET_N = 1'b0;
        #1;
        check("mid_rst_flags", {busy, done, err, in_ready, out_valid, ram_write}, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_addr", ram_addra, 0);
        check("mid_rst_ram_data", ram_data, 0);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        @(negedge CLOCK);
        check("mid_post_idle", {busy, out_valid, ram_write}, 0);
        run_cmd(1'b0, 'h123, 2, 2, 1'b0);

        run_cmd(1'b0, 'h050, 0, 0, 1'b0);
        run_cmd(1'b1, 'h060, 0, 0, 1'b0);
        run_cmd(1'b0, 'h3FF, 2, 0, 1'b0);
        run_cmd(1'b1, 'h3FF, 2, 2, 1'b0);

        for (int n = 0; n < 14; n++) begin
            run_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, WORDS - 1)),
                    int'($urandom_range(0, 24)), int'($urandom_range(0, 2)), 1'b0);
        end
        run_cmd(1'b1, 'h200, 64, 2, 1'b0);
        run_cmd(1'b0, 'h200, 64, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
